// File: rtl/sync_debounce_edge_pkg.sv
// Shared definitions for the debounce/edge front end:
// the state encoding and the counter width helper.
package sync_debounce_edge_pkg;

   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_CHK_HIGH = 2'd1,
      S_HIGH     = 2'd2,
      S_CHK_LOW  = 2'd3
   } state_t;

   // Index of the highest set bit; 0 for an input of 0 so a width derived from
   // it is never zero.
   function automatic int f_msb(input int unsigned value);
      int msb;
      msb = 0;
      for (int i = 0; i < 32; i++) begin
         if (value[i]) msb = i;
      end
      return msb;
   endfunction

endpackage

// File: rtl/bit_sync.sv
// Single-bit synchroniser: a STAGES-deep flop chain with a synchronous
// active-low reset to a configurable level.
module bit_sync #(
   parameter int   STAGES = 2,
   parameter logic INIT   = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // NOTE: non-blocking assignment so each stage captures the previous stage's
   // value from before the edge; blocking here would collapse the chain.
   always_ff @(posedge clk) begin
      if (!rst) chain <= {STAGES{INIT}};
      else      chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// Synchronise, debounce and edge-detect one asynchronous input; also keeps a
// saturating count of rejected candidate edges.
module sync_debounce_edge
   import sync_debounce_edge_pkg::*;
#(
   parameter int   SYNC_STAGES = 2,
   parameter int   DEB_CNT     = 1000,
   parameter logic INIT_LEVEL  = 1'b0,
   parameter int   GCNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sig_async,
   input  logic              clr_glitch,
   output logic              level,
   output logic              rise_pulse,
   output logic              fall_pulse,
   output logic              glitch_pulse,
   output logic [GCNT_W-1:0] glitch_cnt
);

   localparam int                CNT_W    = f_msb(DEB_CNT - 1) + 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEB_CNT - 1);
   localparam logic [GCNT_W-1:0] GCNT_MAX = '1;

   logic              sync_q;
   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              level_nxt;
   logic              rise_ev, fall_ev, glitch_ev;
   logic [GCNT_W-1:0] gcnt_nxt;

   bit_sync #(
      .STAGES (SYNC_STAGES),
      .INIT   (INIT_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (sig_async),
      .q   (sync_q)
   );

   // NOTE: every variable gets a default before the case so no path leaves
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      level_nxt = level;
      rise_ev   = 1'b0;
      fall_ev   = 1'b0;
      glitch_ev = 1'b0;
      case (state)
         S_LOW: begin
            if (sync_q) begin
               state_nxt = S_CHK_HIGH;
               cnt_nxt   = '0;
            end
         end
         S_CHK_HIGH: begin
            if (!sync_q) begin
               state_nxt = S_LOW;
               glitch_ev = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HIGH;
               level_nxt = 1'b1;
               rise_ev   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         S_HIGH: begin
            if (!sync_q) begin
               state_nxt = S_CHK_LOW;
               cnt_nxt   = '0;
            end
         end
         S_CHK_LOW: begin
            if (sync_q) begin
               state_nxt = S_HIGH;
               glitch_ev = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_LOW;
               level_nxt = 1'b0;
               fall_ev   = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = S_LOW;
      endcase
   end

   // Clear takes effect first, so a coincident glitch still counts as one.
   always_comb begin
      gcnt_nxt = glitch_cnt;
      if (clr_glitch) gcnt_nxt = '0;
      if (glitch_ev && (gcnt_nxt != GCNT_MAX)) gcnt_nxt = gcnt_nxt + GCNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= INIT_LEVEL ? S_HIGH : S_LOW;
         cnt          <= '0;
         level        <= INIT_LEVEL;
         rise_pulse   <= 1'b0;
         fall_pulse   <= 1'b0;
         glitch_pulse <= 1'b0;
         glitch_cnt   <= '0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         level        <= level_nxt;
         rise_pulse   <= rise_ev;
         fall_pulse   <= fall_ev;
         glitch_pulse <= glitch_ev;
         glitch_cnt   <= gcnt_nxt;
      end
   end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: directed scenarios followed by random input
// runs, all compared each cycle against a run-length reference model.
module tb_sync_debounce_edge;

   localparam int   SYNC_STAGES = 2;
   localparam int   DEB_CNT     = 4;
   localparam logic INIT_LEVEL  = 1'b0;
   localparam int   GCNT_W      = 8;
   localparam int   GCNT_MAX    = (1 << GCNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              sig_async;
   logic              clr_glitch;
   logic              level;
   logic              rise_pulse;
   logic              fall_pulse;
   logic              glitch_pulse;
   logic [GCNT_W-1:0] glitch_cnt;

   always #5 clk = ~clk;

   sync_debounce_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CNT     (DEB_CNT),
      .INIT_LEVEL  (INIT_LEVEL),
      .GCNT_W      (GCNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sig_async    (sig_async),
      .clr_glitch   (clr_glitch),
      .level        (level),
      .rise_pulse   (rise_pulse),
      .fall_pulse   (fall_pulse),
      .glitch_pulse (glitch_pulse),
      .glitch_cnt   (glitch_cnt)
   );

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   // Reference model: input delay line plus the length of the current run of
   // synchronised samples that disagree with the accepted level.
   logic m_pipe [SYNC_STAGES];
   logic m_level;
   int   m_run;
   logic m_rise, m_fall, m_glitch;
   int   m_gcnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s (cycle %0d): observed %0d expected %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic s, input logic c);
      logic sq;
      if (!r) begin
         for (int i = 0; i < SYNC_STAGES; i++) m_pipe[i] = INIT_LEVEL;
         m_level  = INIT_LEVEL;
         m_run    = 0;
         m_rise   = 1'b0;
         m_fall   = 1'b0;
         m_glitch = 1'b0;
         m_gcnt   = 0;
         return;
      end
      sq = m_pipe[SYNC_STAGES-1];
      for (int i = SYNC_STAGES - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = s;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      m_glitch = 1'b0;
      if (sq != m_level) begin
         m_run++;
         if (m_run == DEB_CNT + 1) begin
            m_level = sq;
            m_run   = 0;
            if (sq) m_rise = 1'b1;
            else    m_fall = 1'b1;
         end
      end else if (m_run > 0) begin
         m_glitch = 1'b1;
         m_run    = 0;
      end
      if (c) m_gcnt = 0;
      if (m_glitch && m_gcnt < GCNT_MAX) m_gcnt++;
   endtask

   task automatic step(input logic r, input logic s, input logic c);
      @(negedge clk);
      rst        = r;
      sig_async  = s;
      clr_glitch = c;
      @(posedge clk);
      cyc++;
      model_edge(r, s, c);
      #1;
      check("level",        level,        m_level);
      check("rise_pulse",   rise_pulse,   m_rise);
      check("fall_pulse",   fall_pulse,   m_fall);
      check("glitch_pulse", glitch_pulse, m_glitch);
      check("glitch_cnt",   glitch_cnt,   m_gcnt);
   endtask

   initial begin
      int   remaining;
      logic v;
      rst        = 1'b0;
      sig_async  = 1'b0;
      clr_glitch = 1'b0;

      // Reset with the input already high, then acceptance 7 edges later.
      repeat (3) step(1'b0, 1'b1, 1'b0);
      check("t1_reset_level", level, 0);
      check("t1_reset_rise", rise_pulse, 0);
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k == 6) check("t1_level_before", level, 0);
         if (k == 7) begin
            check("t1_rise_at_7", rise_pulse, 1);
            check("t1_level_at_7", level, 1);
         end
      end
      step(1'b1, 1'b1, 1'b0);
      check("t1_rise_one_cycle", rise_pulse, 0);

      // Falling acceptance from level 1.
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 1'b0, 1'b0);
         if (k == 7) begin
            check("t4_fall_at_7", fall_pulse, 1);
            check("t4_level_at_7", level, 0);
         end
      end
      step(1'b1, 1'b0, 1'b0);
      check("t4_fall_one_cycle", fall_pulse, 0);

      // Three-clock glitch is rejected.
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b0);
      check("t2_glitch_cnt", glitch_cnt, 1);
      check("t2_level", level, 0);

      // Four samples rejected, five accepted.
      repeat (4) step(1'b1, 1'b1, 1'b0);
      repeat (6) step(1'b1, 1'b0, 1'b0);
      check("t3_four_rejected", glitch_cnt, 2);
      check("t3_four_level", level, 0);
      repeat (5) step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      check("t3_five_accepted", level, 1);
      check("t3_five_no_glitch", glitch_cnt, 2);
      repeat (8) step(1'b1, 1'b0, 1'b0);
      check("t3_back_low", level, 0);

      // Saturation, then clear coincident with a glitch event.
      for (int g = 0; g < 300; g++) begin
         repeat (2) step(1'b1, 1'b1, 1'b0);
         repeat (3) step(1'b1, 1'b0, 1'b0);
      end
      check("t5_saturated", glitch_cnt, GCNT_MAX);
      repeat (2) step(1'b1, 1'b1, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b1);
      check("t5_clr_glitch_pulse", glitch_pulse, 1);
      check("t5_clr_and_count", glitch_cnt, 1);

      // Reset in the middle of a rising check.
      repeat (5) step(1'b1, 1'b1, 1'b0);
      check("t6_pre_level", level, 0);
      repeat (2) step(1'b0, 1'b1, 1'b0);
      check("t6_rst_level", level, 0);
      check("t6_rst_rise", rise_pulse, 0);
      check("t6_rst_glitch", glitch_pulse, 0);
      check("t6_rst_gcnt", glitch_cnt, 0);
      for (int k = 1; k <= 7; k++) begin
         step(1'b1, 1'b1, 1'b0);
         if (k == 6) check("t6_level_before", level, 0);
         if (k == 7) check("t6_rise_at_7", rise_pulse, 1);
      end

      // Random runs of varying length with occasional clear and reset.
      remaining = 0;
      v         = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (remaining == 0) begin
            v         = ~v;
            remaining = int'($urandom_range(1, 9));
         end
         remaining--;
         step(($urandom_range(0, 299) != 0), v, ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
